// File: rtl/jam_cost_table.sv
// ============================================================================
// Module   : jam_cost_table
// Brief    : 8x8 cost matrix loaded over valid/ready, with combinational lookup
//            and a running sum of per-worker row minimums (LowerBound).
//            Optional parity protection enabled by macro COST_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jam_cost_table #(
    parameter int N  = 8,
    parameter int CW = 7,
    parameter int SW = 10
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    input  logic [CW-1:0] in_data,
    output logic          in_ready,
    input  logic          reload,
    input  logic [2:0]    W,
    input  logic [2:0]    J,
    output logic [CW-1:0] Cost,
    output logic          Ready,
    output logic [SW-1:0] LowerBound
`ifdef COST_PARITY_EN
    ,
    input  logic          in_par,
    output logic          ParErr
`endif
);

    localparam logic [1:0]    IDLE    = 2'd0;
    localparam logic [1:0]    LOAD    = 2'd1;
    localparam logic [1:0]    DONE    = 2'd2;
    localparam logic [CW-1:0] MAX_COST = '1;

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [5:0]    k;
    logic [CW-1:0] row_min;
    logic [SW-1:0] acc;
    logic [CW-1:0] mem [0:N*N-1];

    logic          xfer;
    logic          restart;
    logic [CW-1:0] new_min;
    logic [SW-1:0] acc_next;
    logic [CW-1:0] rd_word;

    // A reload in the same cycle as a transfer wins: the word is dropped.
    assign restart  = reload && (state != IDLE);
    assign xfer     = in_valid && (state == LOAD) && !reload;
    assign new_min  = (in_data < row_min) ? in_data : row_min;
    assign acc_next = acc + {{(SW-CW){1'b0}}, new_min};
    assign rd_word  = mem[{W, J}];

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = LOAD;
            LOAD:    if (xfer && (k == 6'd63)) next_state = DONE;
            DONE:    if (reload) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state == LOAD);
        Ready    = (state == DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            k          <= '0;
            row_min    <= MAX_COST;
            acc        <= '0;
            LowerBound <= '0;
        end else if (restart) begin
            k          <= '0;
            row_min    <= MAX_COST;
            acc        <= '0;
            LowerBound <= '0;
        end else if (xfer) begin
            k <= k + 6'd1;
            if (k[2:0] == 3'd7) begin
                acc     <= acc_next;
                row_min <= MAX_COST;
                if (k == 6'd63) LowerBound <= acc_next;
            end else begin
                row_min <= new_min;
            end
        end
    end

    // Matrix storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (xfer) mem[k] <= in_data;
    end

`ifdef COST_PARITY_EN
    logic par_mem [0:N*N-1];
    logic rd_bad;
    logic in_bad;

    assign rd_bad = ^{rd_word, par_mem[{W, J}]};
    assign in_bad = ^{in_data, in_par};

    always_ff @(posedge CLK) begin
        if (xfer) par_mem[k] <= in_par;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ParErr <= 1'b0;
        end else if (restart) begin
            ParErr <= 1'b0;
        end else if ((xfer && in_bad) || ((state == DONE) && rd_bad)) begin
            ParErr <= 1'b1;
        end
    end

    always_comb begin
        Cost = '0;
        if (state == DONE) Cost = rd_bad ? MAX_COST : rd_word;
    end
`else
    always_comb begin
        Cost = '0;
        if (state == DONE) Cost = rd_word;
    end
`endif

endmodule

`default_nettype wire

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Upstream stage of the job-assignment engine; owns the 8x8 worker/job cost matrix.
- Accepts a 64-entry row-major cost stream over a valid/ready handshake and stores it.
- Then serves combinational Cost lookups for the engine's (W,J) address pair.
- During load it also computes LowerBound, the sum of per-worker row minimums, which downstream may use for pruning or sanity checking.

Parameters:
- N, 8, workers/jobs per side; index width fixed at 3 bits.
- CW, 7, cost word width.
- SW, 10, LowerBound/sum width; must hold N*(2^CW-1)=1016.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  1  cost stream word valid.
- in_data  input  7  cost word; entry k is worker k/8, job k%8.
- in_ready  output  1  table accepting words.
- reload  input  1  single-cycle request to discard the table and accept a new stream.
- W  input  3  worker index from the engine.
- J  input  3  job index from the engine.
- Cost  output  7  cost of (W,J); combinational.
- Ready  output  1  table complete; holds the downstream engine in reset while low.
- LowerBound  output  10  sum of 8 row minimums; valid when Ready=1.

Behaviour:
- Reset values: in_ready=0, Ready=0, Cost=0, LowerBound=0, load counter k=0, row_min=127, acc=0, state=IDLE. Matrix contents are not reset.
- States: IDLE -> LOAD -> DONE. A reload in DONE returns to LOAD.
- IDLE: lasts exactly one cycle after reset deassertion, then goes to LOAD.
- LOAD: in_ready=1. A transfer occurs when in_valid&in_ready on a rising edge.
  - On a transfer: mem[k[5:3]][k[2:0]]<=in_data; k<=k+1.
  - row_min <= min(row_min, in_data), except at k[2:0]==7.
  - At k[2:0]==7: acc<=acc+min(row_min,in_data) and row_min<=127.
  - in_valid low stalls with no state change. Bubbles of any length are legal.
- After the transfer at k==63: state<=DONE, Ready<=1, LowerBound<=final acc (including row 7), in_ready<=0.
  - in_ready drops in the same cycle Ready rises, so there is zero extra latency.
- DONE: Cost=mem[W][J] with no register, so there is no latency between W/J and Cost. in_valid is ignored.
- Cost=0 whenever Ready=0.
- reload:
  - In DONE: next cycle Ready=0, LowerBound=0, k=0, acc=0, row_min=127, state=LOAD.
  - In LOAD: restarts the count at k=0. Any transfer in the same cycle is discarded.
  - In IDLE: ignored.
- Arithmetic: acc is 10-bit unsigned and cannot overflow at CW=7. Min comparisons are unsigned.
- RST mid-load: everything returns to reset values at once and the partial table is abandoned.
- Back-to-back streaming: 64 consecutive valid cycles load in exactly 64 cycles.

Optional Feature:
- Macro COST_PARITY_EN.
- When defined:
  - Adds input in_par (1 bit, even parity over in_data) and output ParErr (1 bit, reset 0).
  - Each mem entry stores a parity bit.
  - A mismatch on any accepted word sets ParErr sticky. ParErr is cleared only by RST or reload.
  - In DONE, a read whose stored parity mismatches forces Cost=127 and sets ParErr.
- When undefined: those ports and the storage bit do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then stream entry k = (k*7)%100 with no bubbles -> Ready rises after the 64th transfer. Cost(W=3,J=5)=(29*7)%100=3. LowerBound equals the sum of row minimums computed by the model.
- All 64 words = 127 -> LowerBound=1016, no overflow. Every W,J reads 127.
- Stream with in_valid toggling 1,0,0,1,... -> the table is identical to the bubble-free case. in_ready stays 1 throughout LOAD.
- After DONE, pulse reload and stream all zeros -> Ready is 0 for the whole reload. Cost=0 during LOAD. Then LowerBound=0 and every Cost=0.
- Assert RST after 30 transfers, then stream a fresh 64 words -> Ready=1 only after 64 new transfers. LowerBound reflects only the new data.
- COST_PARITY_EN: send word 5 with in_par=1 (wrong) -> ParErr=1 the next cycle and stays 1 after Ready. Reading (0,5) gives Cost=127. A reload clears ParErr.
